// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : fetch_stage
// Brief    : Instruction fetch stage; owns the PC, issues I-cache reads and
//            hands one instruction per accepted cycle to the IF/ID register.
// Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic [31:0] instr_out,
  output logic [31:0] pc_4_out,
  output logic        valid_out,
  output logic [31:0] fetch_count,
  output logic        halted
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [31:0] C_PC_STEP = 32'd4;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  logic [31:0] r_fetch_count;

  logic        w_accept;
  logic [31:0] w_pc_4;
  logic [31:0] w_redirect_target;
  logic        w_unused_ok;

  assign w_pc_4            = r_pc + C_PC_STEP;
  assign w_redirect_target = {redirect_pc[31:2], 2'b00};
  assign w_unused_ok       = &{1'b0, redirect_pc[1:0]};

  // An instruction leaves only when nothing of higher priority claims the cycle.
  always_comb begin
    w_accept = 1'b0;
    case (r_state)
      RUN:     w_accept = ihit & ~stall & ~redirect & ~halt;
      HOLD:    w_accept = ~stall & ~redirect & ~halt;
      default: w_accept = 1'b0;
    endcase
    w_accept = w_accept & nRST;
  end

  assign valid_out   = w_accept;
  assign instr_out   = w_accept ? ((r_state == HOLD) ? r_buf : iload) : 32'd0;
  assign iREN        = nRST & (r_state == RUN);
  assign iaddr       = r_pc;
  assign pc_4_out    = w_pc_4;
  assign fetch_count = r_fetch_count;
  assign halted      = (r_state == HALT);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state       <= RUN;
      r_pc          <= PC_INIT;
      r_buf         <= 32'd0;
      r_fetch_count <= 32'd0;
    end else begin
      if (w_accept) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      case (r_state)
        RUN: begin
          if (halt) begin
            r_state <= HALT;
          end else if (redirect) begin
            r_pc <= w_redirect_target;
          end else if (ihit) begin
            if (stall) begin
              // Park the returned word so the cache need not be re-read.
              r_buf   <= iload;
              r_state <= HOLD;
            end else begin
              r_pc <= w_pc_4;
            end
          end
        end
        HOLD: begin
          if (halt) begin
            r_state <= HALT;
          end else if (redirect) begin
            r_pc    <= w_redirect_target;
            r_state <= RUN;
          end else if (!stall) begin
            r_pc    <= w_pc_4;
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= HALT;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_stage
// Brief    : Directed plus random bench for fetch_stage, two PC_INIT values.
// Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic        halt = 1'b0;
  logic [31:0] iload = 32'd0;
  logic [31:0] redirect_pc = 32'd0;

  logic [1:0]       w_iren;
  logic [1:0][31:0] w_iaddr;
  logic [1:0][31:0] w_instr;
  logic [1:0][31:0] w_pc4;
  logic [1:0]       w_valid;
  logic [1:0][31:0] w_cnt;
  logic [1:0]       w_halted;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state per instance: plain PC / counters / flags.
  logic [31:0] m_pc  [2];
  logic [31:0] m_buf [2];
  logic [31:0] m_cnt [2];
  bit          m_hold[2];
  bit          m_halt[2];

  always #5 CLK = ~CLK;

  fetch_stage #(.PC_INIT(32'h0000_0000)) u_dut0 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload),
    .iREN(w_iren[0]), .iaddr(w_iaddr[0]), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr_out(w_instr[0]), .pc_4_out(w_pc4[0]), .valid_out(w_valid[0]),
    .fetch_count(w_cnt[0]), .halted(w_halted[0])
  );

  fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) u_dut1 (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload),
    .iREN(w_iren[1]), .iaddr(w_iaddr[1]), .stall(stall),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr_out(w_instr[1]), .pc_4_out(w_pc4[1]), .valid_out(w_valid[1]),
    .fetch_count(w_cnt[1]), .halted(w_halted[1])
  );

  function automatic logic [31:0] init_of(input int k);
    return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k]   = init_of(k);
      m_buf[k]  = 32'd0;
      m_cnt[k]  = 32'd0;
      m_hold[k] = 1'b0;
      m_halt[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (m_halt[k]) begin
        // frozen until reset
      end else if (halt) begin
        m_halt[k] = 1'b1;
      end else if (redirect) begin
        m_pc[k]   = {redirect_pc[31:2], 2'b00};
        m_hold[k] = 1'b0;
      end else if (m_hold[k]) begin
        if (!stall) begin
          m_pc[k]   = m_pc[k] + 32'd4;
          m_cnt[k]  = m_cnt[k] + 32'd1;
          m_hold[k] = 1'b0;
        end
      end else if (ihit) begin
        if (stall) begin
          m_buf[k]  = iload;
          m_hold[k] = 1'b1;
        end else begin
          m_pc[k]  = m_pc[k] + 32'd4;
          m_cnt[k] = m_cnt[k] + 32'd1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    bit          acc;
    logic [31:0] ei;
    for (int k = 0; k < 2; k++) begin
      acc = nRST && !m_halt[k] && !halt && !redirect && !stall && (m_hold[k] || ihit);
      ei  = acc ? (m_hold[k] ? m_buf[k] : iload) : 32'd0;
      chk($sformatf("iREN[%0d]", k),        {31'd0, w_iren[k]},
          {31'd0, nRST && !m_halt[k] && !m_hold[k]});
      chk($sformatf("iaddr[%0d]", k),       w_iaddr[k], m_pc[k]);
      chk($sformatf("pc_4_out[%0d]", k),    w_pc4[k], m_pc[k] + 32'd4);
      chk($sformatf("valid_out[%0d]", k),   {31'd0, w_valid[k]}, {31'd0, acc});
      chk($sformatf("instr_out[%0d]", k),   w_instr[k], ei);
      chk($sformatf("fetch_count[%0d]", k), w_cnt[k], m_cnt[k]);
      chk($sformatf("halted[%0d]", k),      {31'd0, w_halted[k]}, {31'd0, m_halt[k]});
    end
  endtask

  // Inputs are driven just after the falling edge; check, then clock the model.
  task automatic tick();
    #1;
    check_outputs();
    @(posedge CLK);
    if (nRST) model_step();
    else model_reset();
    @(negedge CLK);
  endtask

  task automatic drive(input bit h, input logic [31:0] w, input bit s,
                       input bit r, input logic [31:0] rp, input bit hl);
    ihit = h; iload = w; stall = s; redirect = r; redirect_pc = rp; halt = hl;
  endtask

  task automatic async_reset_pulse();
    #2;
    nRST = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge CLK);
    tick();
    nRST = 1'b1;
  endtask

  task automatic random_run(input int cycles, input int halt_pct);
    for (int i = 0; i < cycles; i++) begin
      drive($urandom_range(0, 99) < 70, $urandom(), $urandom_range(0, 99) < 25,
            $urandom_range(0, 99) < 8, $urandom(), $urandom_range(0, 99) < halt_pct);
      tick();
      if (m_halt[0] && $urandom_range(0, 99) < 10) async_reset_pulse();
    end
  endtask

  initial begin
    model_reset();
    @(negedge CLK);

    // Reset held
    drive(1'b1, 32'h2001_0001, 1'b0, 1'b0, 32'd0, 1'b0);
    tick();
    tick();
    chk("reset pc_4 wrap", w_pc4[1], 32'h0000_0000);
    nRST = 1'b1;

    // Zero-wait stream
    drive(1'b1, 32'h2001_0001, 1'b0, 1'b0, 32'd0, 1'b0); tick();
    drive(1'b1, 32'h2002_0002, 1'b0, 1'b0, 32'd0, 1'b0); tick();
    drive(1'b1, 32'h0022_1820, 1'b0, 1'b0, 32'd0, 1'b0); tick();
    chk("stream count", w_cnt[0], 32'd3);
    chk("stream iaddr", w_iaddr[0], 32'h0000_000C);
    chk("wrap iaddr", w_iaddr[1], 32'h0000_0008);

    // Miss then hit
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, $urandom(), 1'b0, 1'b0, 32'd0, 1'b0);
      tick();
    end
    drive(1'b1, 32'h8C23_0000, 1'b0, 1'b0, 32'd0, 1'b0); tick();

    // Stall into HOLD and release
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hAC22_0000, 1'b1, 1'b0, 32'd0, 1'b0);
      tick();
    end
    drive(1'b0, 32'h1234_5678, 1'b0, 1'b0, 32'd0, 1'b0);
    #1;
    chk("hold release instr", w_instr[0], 32'hAC22_0000);
    tick();

    // Redirect in RUN, then in HOLD
    drive(1'b1, 32'h1111_1111, 1'b0, 1'b1, 32'h0000_0103, 1'b0); tick();
    chk("redirect run iaddr", w_iaddr[0], 32'h0000_0100);
    drive(1'b1, 32'h2222_2222, 1'b1, 1'b0, 32'd0, 1'b0); tick();
    drive(1'b1, 32'h3333_3333, 1'b1, 1'b1, 32'h0000_0103, 1'b0); tick();
    chk("redirect hold iaddr", w_iaddr[0], 32'h0000_0100);
    chk("redirect hold iREN", {31'd0, w_iren[0]}, 32'd1);

    // Async reset while in HOLD and mid-miss
    drive(1'b1, 32'h4444_4444, 1'b1, 1'b0, 32'd0, 1'b0); tick();
    async_reset_pulse();
    drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0); tick();
    async_reset_pulse();

    random_run(300, 0);

    // Halt with simultaneous redirect at pc 0x20
    drive(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0020, 1'b0); tick();
    drive(1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h0000_0400, 1'b1); tick();
    chk("halt halted", {31'd0, w_halted[0]}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      drive(i[0], $urandom(), 1'b0, ~i[0], $urandom(), 1'b0);
      tick();
    end
    chk("halt iaddr frozen", w_iaddr[0], 32'h0000_0020);
    async_reset_pulse();
    chk("post-halt iaddr", w_iaddr[0], 32'h0000_0000);

    random_run(600, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the five-stage pipeline. It owns the program counter, drives the instruction-side cache request (iREN/iaddr), and presents one fetched instruction per accepted cycle to the IF/ID pipeline register (instr and pc+4 inputs). It absorbs cache misses, hazard stalls, control-flow redirects from later stages and halt. When no instruction is valid it emits a zero word, which the downstream register treats as a bubble (sll $0).

## Interface
Parameters:
- PC_INIT, 32'h0000_0000, program counter value after reset

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  reset, asynchronous, active-low
- ihit  in  1  instruction cache hit; iload valid this cycle
- iload  in  32  instruction word from cache
- iREN  out  1  instruction read request
- iaddr  out  32  instruction address (always equals pc)
- stall  in  1  hazard unit hold request; no instruction may be passed downstream
- redirect  in  1  taken branch/jump/JR resolved downstream; flush fetch
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced to 00)
- halt  in  1  halt has reached writeback; fetching stops permanently
- instr_out  out  32  instruction to IF/ID; 0 when valid_out=0
- pc_4_out  out  32  pc+4 of current pc, modulo 2^32
- valid_out  out  1  instr_out carries a real instruction this cycle
- fetch_count  out  32  number of valid_out cycles since reset, wraps
- halted  out  1  state is HALT

## Operation
- State register: RUN, HOLD, HALT. Also pc (32), buf (32), fetch_count (32).
- Priority every cycle: halt > redirect > stall > ihit.
- RUN: iREN=1, iaddr=pc.
  - halt: next HALT, pc unchanged, valid_out=0.
  - redirect: pc <= {redirect_pc[31:2],2'b00}, stay RUN, valid_out=0, word returned this cycle (if any) discarded.
  - ihit & !stall: valid_out=1, instr_out=iload, pc <= pc+4, fetch_count++.
  - ihit & stall: buf <= iload, next HOLD, pc unchanged, valid_out=0.
  - !ihit: miss; pc and iaddr held, valid_out=0.
- HOLD: iREN=0, word already in buf.
  - halt: next HALT.
  - redirect: pc <= aligned redirect_pc, next RUN, buf dropped.
  - !stall: valid_out=1, instr_out=buf, pc <= pc+4, fetch_count++, next RUN.
  - stall: remain HOLD.
- HALT: iREN=0, valid_out=0, instr_out=0, pc frozen; all inputs ignored; exit only through nRST.
- Arithmetic: pc+4 is 32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000. fetch_count wraps at 2^32.

## Timing
- Reset values (held while nRST=0): state RUN, pc=PC_INIT, buf=0, fetch_count=0; outputs iREN=0 (forced while nRST low), iaddr=PC_INIT, instr_out=0, valid_out=0, pc_4_out=PC_INIT+4, halted=0.
- First cycle after nRST rises: iREN=1, iaddr=PC_INIT.
- valid_out, instr_out are combinational from state, ihit, iload, stall, redirect, halt in the same cycle; pc, state, buf, fetch_count update on the rising CLK edge.
- Zero-wait cache (ihit=1 continuously, no stall): one instruction per cycle, pc advances by 4 every cycle.
- Miss latency: iaddr stable from request until ihit; pc advances the edge after ihit.
- Redirect: target appears on iaddr the cycle after redirect; the fetch in the redirect cycle is always dropped.
- Asynchronous reset mid-miss, mid-HOLD or in HALT: immediate return to reset values; buffered word lost.
- halted rises the cycle after halt is sampled.

## Test plan
- Reset with PC_INIT=0, ihit=1, iload=0x20010001, 0x20020002, 0x00221820, stall=0 -> iaddr 0x0,0x4,0x8; valid_out=1 each cycle with matching instr_out; fetch_count=3; pc_4_out 0x4,0x8,0xC.
- At pc=0x4, ihit=0 for 3 cycles -> iREN=1, iaddr=0x4, valid_out=0, instr_out=0 throughout; ihit=1 with iload=0x8C230000 -> valid_out=1, next iaddr=0x8.
- ihit=1, iload=0xAC220000, stall=1 for 3 cycles -> HOLD, iREN=0 in cycles 2-3, instr_out=0; stall drops -> instr_out=0xAC220000, valid_out=1, pc+4, iREN=1 next cycle.
- In RUN, ihit=1 and redirect=1 with redirect_pc=0x0000_0103 -> valid_out=0, fetch_count unchanged, next iaddr=0x0000_0100; same redirect while in HOLD -> buf dropped, RUN, iaddr=0x100.
- halt=1, redirect=1 same cycle at pc=0x20 -> next cycle halted=1, iREN=0, iaddr=0x20; ihit/redirect toggled 10 cycles -> no change; nRST pulse -> pc=PC_INIT, halted=0.
- PC_INIT=0xFFFF_FFFC -> pc_4_out=0x0 at reset; one ihit -> iaddr=0x0000_0000, pc_4_out=0x4.
